// File: rtl/sram_fifo_ctrl_if.sv
// Stream and macro-side signal bundle for sram_fifo_ctrl.
//   push_*  : write stream into the FIFO (valid/ready)
//   pop_*   : read stream out of the FIFO (valid/ready, registered data)
//   count/full/empty : occupancy status
//   sram_*  : single-port macro pins (active-low CEB/WEB, Q valid one cycle after a read)
// The slave modport is the controller; the master modport is the core datapath plus the macro.
interface sram_fifo_ctrl_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  push_valid;
    logic [WIDTH-1:0]      push_data;
    logic                  push_ready;
    logic                  pop_valid;
    logic [WIDTH-1:0]      pop_data;
    logic                  pop_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  sram_ceb;
    logic                  sram_web;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [WIDTH-1:0]      sram_d;
    logic [WIDTH-1:0]      sram_q;

    modport slave (
        input  push_valid, push_data, pop_ready, sram_q,
        output push_ready, pop_valid, pop_data, count, full, empty,
        output sram_ceb, sram_web, sram_a, sram_d
    );

    modport master (
        output push_valid, push_data, pop_ready, sram_q,
        input  push_ready, pop_valid, pop_data, count, full, empty,
        input  sram_ceb, sram_web, sram_a, sram_d
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller using one single-port SRAM macro as storage.
// One macro access per cycle: push writes win unless the output buffer is starved, otherwise
// a prefetch read refills a 2-entry output buffer that hides the macro's one-cycle read latency.
// Ports:
//   clk   : clock shared with the macro
//   reset : asynchronous active-low reset
//   flush : synchronous clear of all FIFO state (SRAM contents untouched)
//   bus   : push/pop streams, status and macro pins (see sram_fifo_ctrl_if)
module sram_fifo_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    sram_fifo_ctrl_if.slave   bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CntDepth = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   sram_words_q, sram_words_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [WIDTH-1:0]      buf_q [2];
    logic [WIDTH-1:0]      buf_d [2];

    logic [1:0] pending;
    logic       have_words, rd_hi, rd_lo, rd_en;
    logic       push_ready, push_fire, pop_fire;

    // Buffered plus in-flight words; a read is only issued while this is below 2.
    assign pending    = occ_q + {1'b0, rd_inflight_q};
    assign have_words = (sram_words_q != '0);
    assign rd_hi      = have_words && (pending == 2'd0);
    // Gated by reset so the handshake is dead while reset is held low.
    assign push_ready = reset && !flush && (count_q < CntDepth) && !rd_hi;
    assign push_fire  = bus.push_valid && push_ready;
    assign rd_lo      = have_words && (pending < 2'd2) && !push_fire;
    assign rd_en      = !flush && !push_fire && (rd_hi || rd_lo);
    assign pop_fire   = (occ_q != 2'd0) && bus.pop_ready;

    // Macro pins and status outputs
    always_comb begin
        bus.push_ready = push_ready;
        bus.pop_valid  = (occ_q != 2'd0);
        bus.pop_data   = buf_q[0];
        bus.count      = count_q;
        bus.full       = (count_q == CntDepth);
        bus.empty      = (count_q == '0);
        bus.sram_ceb   = !(push_fire || rd_en);
        bus.sram_web   = !push_fire;
        bus.sram_a     = push_fire ? wr_ptr_q : rd_ptr_q;
        bus.sram_d     = bus.push_data;
    end

    // Next-state
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        sram_words_d  = sram_words_q;
        count_d       = count_q;
        rd_inflight_d = rd_en;
        occ_d         = occ_q;
        buf_d         = buf_q;

        if (push_fire) begin
            wr_ptr_d     = wr_ptr_q + PtrOne;
            sram_words_d = sram_words_q + CntOne;
        end else if (rd_en) begin
            rd_ptr_d     = rd_ptr_q + PtrOne;
            sram_words_d = sram_words_q - CntOne;
        end

        if (pop_fire) begin
            buf_d[0] = buf_q[1];
            occ_d    = occ_q - 2'd1;
        end
        // Capture lands behind whatever survives the pop; occ_d is at most 1 here.
        if (rd_inflight_q) begin
            buf_d[occ_d[0]] = bus.sram_q;
            occ_d           = occ_d + 2'd1;
        end

        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // A late sram_q is dropped because rd_inflight and occ both clear.
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            sram_words_d  = '0;
            count_d       = '0;
            rd_inflight_d = 1'b0;
            occ_d         = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sram_words_q  <= '0;
            count_q       <= '0;
            rd_inflight_q <= 1'b0;
            occ_q         <= 2'd0;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sram_words_q  <= sram_words_d;
            count_q       <= count_d;
            rd_inflight_q <= rd_inflight_d;
            occ_q         <= occ_d;
            buf_q[0]      <= buf_d[0];
            buf_q[1]      <= buf_d[1];
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural 512x16 macro model.
module tb_sram_fifo_ctrl;
    localparam int W     = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    sram_fifo_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    sram_fifo_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Macro model: array updated at the write edge, Q registered on a read.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!bus.sram_ceb) begin
            if (!bus.sram_web) mem[bus.sram_a] <= bus.sram_d;
            else               bus.sram_q      <= mem[bus.sram_a];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_count = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] exp_word;
    logic mon_pf, mon_qf;
    logic pv_seen = 1'b0;
    int   pv_cyc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset || flush) begin
            if (reset) check("flush_no_sram_op", 32'(bus.sram_ceb), 32'd1);
            sb.delete();
            model_count = 0;
        end else begin
            mon_pf = bus.push_valid && bus.push_ready;
            mon_qf = bus.pop_valid && bus.pop_ready;
            check("count", 32'(bus.count), 32'(model_count));
            check("full", 32'(bus.full), 32'(model_count == DEPTH));
            check("empty", 32'(bus.empty), 32'(model_count == 0));
            check("sram_write_iff_push", 32'(!bus.sram_ceb && !bus.sram_web), 32'(mon_pf));
            if (mon_pf) check("sram_d", 32'(bus.sram_d), 32'(bus.push_data));
            if (mon_qf) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", 32'(bus.pop_data), 32'hFFFF_FFFF);
                end else begin
                    exp_word = sb.pop_front();
                    check("pop_data", 32'(bus.pop_data), 32'(exp_word));
                end
            end
            if (mon_pf) sb.push_back(bus.push_data);
            if (!pv_seen && bus.pop_valid) begin
                pv_seen = 1'b1;
                pv_cyc  = cyc;
            end
            model_count = model_count + int'(mon_pf) - int'(mon_qf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds push_valid until accepted; returns at posedge+1 with push_valid still high.
    task automatic push_word(input logic [W-1:0] d, output int acc_cyc);
        logic done;
        done = 1'b0;
        acc_cyc = 0;
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.push_ready) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
            step();
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int max_cyc);
        logic done;
        done = 1'b0;
        bus.pop_ready = 1'b1;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (bus.empty) done = 1'b1;
            step();
        end
        bus.pop_ready = 1'b0;
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pop_valid"},  32'(bus.pop_valid),  32'd0);
        check({tag, "_pop_data"},   32'(bus.pop_data),   32'd0);
        check({tag, "_push_ready"}, 32'(bus.push_ready), 32'd0);
        check({tag, "_count"},      32'(bus.count),      32'd0);
        check({tag, "_full"},       32'(bus.full),       32'd0);
        check({tag, "_empty"},      32'(bus.empty),      32'd1);
        check({tag, "_sram_ceb"},   32'(bus.sram_ceb),   32'd1);
        check({tag, "_sram_web"},   32'(bus.sram_web),   32'd1);
        check({tag, "_sram_a"},     32'(bus.sram_a),     32'd0);
    endtask

    initial begin
        int first_cyc, acc;
        logic found;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b1;
        step();

        // Back-to-back pushes of 1..5, no pops
        pv_seen = 1'b0;
        push_word(16'h0001, first_cyc);
        for (int d = 2; d <= 5; d++) push_word(W'(d), acc);
        bus.push_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("t1_latency", 32'(pv_cyc - first_cyc), 32'd3);
        check("t1_count", 32'(bus.count), 32'd5);
        check("t1_pop_valid", 32'(bus.pop_valid), 32'd1);
        check("t1_head_held", 32'(bus.pop_data), 32'h0001);
        step();
        drain(50);

        // Fill to DEPTH, extra push refused, drain in order
        for (int i = 0; i < DEPTH; i++) push_word(W'(i), acc);
        bus.push_data = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fill_full", 32'(bus.full), 32'd1);
            check("fill_push_ready", 32'(bus.push_ready), 32'd0);
            check("fill_count", 32'(bus.count), 32'(DEPTH));
            step();
        end
        bus.push_valid = 1'b0;
        drain(2000);
        check("fill_empty", 32'(bus.empty), 32'd1);

        // Wrap-around
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 300; k++) push_word(W'(16'h1000 + r * 300 + k), acc);
            bus.push_valid = 1'b0;
            drain(1000);
        end

        // Random stalls on both sides
        for (int c = 0; c < 2000; c++) begin
            bus.push_valid = 1'($urandom_range(0, 1));
            bus.push_data  = W'($urandom);
            bus.pop_ready  = 1'($urandom_range(0, 1));
            step();
        end
        bus.push_valid = 1'b0;
        drain(2000);

        // Flush in the cycle after a read issue
        for (int k = 0; k < 10; k++) push_word(W'(16'h2000 + k), acc);
        bus.push_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!bus.sram_ceb && bus.sram_web) found = 1'b1;
            step();
        end
        check("flush_read_seen", 32'(found), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_count_before", 32'(bus.count), 32'd10);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_empty", 32'(bus.empty), 32'd1);
        check("flush_pop_valid", 32'(bus.pop_valid), 32'd0);
        step();
        repeat (3) step();
        check("flush_late_q_dropped", 32'(bus.pop_valid), 32'd0);
        push_word(16'hBEEF, acc);
        bus.push_valid = 1'b0;
        drain(20);

        // Reset pulse mid-burst
        bus.pop_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = W'(16'h3000 + c);
            step();
        end
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals("mid");
        @(posedge clk);
        #2;
        reset = 1'b1;
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        step();
        pv_seen = 1'b0;
        push_word(16'h1234, first_cyc);
        bus.push_valid = 1'b0;
        repeat (3) step();
        check("post_reset_latency", 32'(pv_cyc - first_cyc), 32'd3);
        check("post_reset_head", 32'(bus.pop_data), 32'h1234);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
